// File: rtl/pp_acc_pkg.sv
// pp_acc_pkg
// Shared types and constants for the partial-product accumulator.
//   PP_W       width of each signed partial product from the 27x18 split multiplier
//   ACC_W_MAX  widest accumulator the ACC_MAX/ACC_MIN helpers can describe
//   acc_max/acc_min  signed max/min bit patterns for a given width, right-aligned
//   pp_beat_t  one input beat: both partial products plus group framing flags
package pp_acc_pkg;

  localparam int PP_W      = 45;
  localparam int ACC_W_MAX = 128;

  // 2^(w-1)-1 in the low w bits; callers slice [w-1:0].
  function automatic logic [ACC_W_MAX-1:0] acc_max(input int w);
    logic [ACC_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ACC_W_MAX; i++)
      if (i < w - 1) r[i] = 1'b1;
    return r;
  endfunction

  // -2^(w-1) in the low w bits; callers slice [w-1:0].
  function automatic logic [ACC_W_MAX-1:0] acc_min(input int w);
    logic [ACC_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ACC_W_MAX; i++)
      if (i == w - 1) r[i] = 1'b1;
    return r;
  endfunction

  typedef struct packed {
    logic signed [PP_W-1:0] pp_lo;
    logic signed [PP_W-1:0] pp_hi;
    logic                   load;
    logic                   last;
  } pp_beat_t;

endpackage

// File: rtl/pp_acc_sat_add.sv
// pp_acc_sat_add
// Combinational accumulate step: res = load ? sum : acc + sum, evaluated one bit
// wider than the accumulator so overflow is visible, then clamped or wrapped.
//   i_acc   in  ACC_W  current accumulator
//   i_sum   in  ACC_W  re-formed product for this beat
//   i_load  in  1      start of group: ignore i_acc
//   o_res   out ACC_W  new accumulator value
//   o_ovf   out 1      this beat overflowed ACC_W
module pp_acc_sat_add
  import pp_acc_pkg::*;
#(
  parameter int ACC_W    = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic                    i_load,
  output logic signed [ACC_W-1:0] o_res,
  output logic                    o_ovf
);

  localparam logic [ACC_W_MAX-1:0] MAX_F = acc_max(ACC_W);
  localparam logic [ACC_W_MAX-1:0] MIN_F = acc_min(ACC_W);
  localparam logic [ACC_W-1:0]     MAX_V = MAX_F[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     MIN_V = MIN_F[ACC_W-1:0];

  logic [ACC_W:0] w_a, w_b, w_full;
  logic           w_ovf;

  assign w_a    = i_load ? '0 : {i_acc[ACC_W-1], i_acc};
  assign w_b    = {i_sum[ACC_W-1], i_sum};
  assign w_full = w_a + w_b;
  // Top two bits disagree -> result does not fit in ACC_W.
  assign w_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];
  assign o_ovf  = w_ovf;

  always_comb begin
    o_res = w_full[ACC_W-1:0];
    // Bit ACC_W carries the true sign of the wide result.
    if (SATURATE && w_ovf) o_res = w_full[ACC_W] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/pp_accumulator.sv
// pp_accumulator
// Re-forms the 27x18 product from its two partial products and accumulates
// beats into a signed group sum; one result per load..last group.
// Pipeline: S1 input register, S2 product sum, S3 accumulator + output register.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; beat = pp_lo, pp_hi, in_load, in_last
//   out_valid/out_ready   output handshake; out_data (group sum), out_ovf (sticky)
module pp_accumulator
  import pp_acc_pkg::*;
#(
  parameter int ACC_W    = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [PP_W-1:0]  pp_lo,
  input  logic signed [PP_W-1:0]  pp_hi,
  input  logic                    in_load,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);

  logic                    w_stall;
  logic [1:0]              r_vld_pipe;  // [0]=S1, [1]=S2
  pp_beat_t                r_s1;
  logic signed [ACC_W-1:0] r_s2_sum;
  logic                    r_s2_load, r_s2_last;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sticky;
  logic signed [ACC_W-1:0] w_res;
  logic                    w_ovf, w_sticky_nxt, w_s3_last;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_out_ovf;

  // Only a full output register that is not being drained freezes the pipe.
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // S1: capture the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[0] <= 1'b0;
      r_s1          <= '0;
    end else if (!w_stall) begin
      r_vld_pipe[0] <= in_valid;
      if (in_valid) begin
        r_s1.pp_lo <= pp_lo;
        r_s1.pp_hi <= pp_hi;
        r_s1.load  <= in_load;
        r_s1.last  <= in_last;
      end
    end
  end

  // S2: re-form the full product at accumulator width (cannot overflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_s2_sum      <= '0;
      r_s2_load     <= 1'b0;
      r_s2_last     <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      if (r_vld_pipe[0]) begin
        r_s2_sum  <= {{(ACC_W-PP_W){r_s1.pp_lo[PP_W-1]}}, r_s1.pp_lo}
                   + {{(ACC_W-PP_W){r_s1.pp_hi[PP_W-1]}}, r_s1.pp_hi};
        r_s2_load <= r_s1.load;
        r_s2_last <= r_s1.last;
      end
    end
  end

  pp_acc_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_acc  (r_acc),
    .i_sum  (r_s2_sum),
    .i_load (r_s2_load),
    .o_res  (w_res),
    .o_ovf  (w_ovf)
  );

  assign w_sticky_nxt = (r_s2_load ? 1'b0 : r_sticky) | w_ovf;
  assign w_s3_last    = r_vld_pipe[1] & r_s2_last;

  // S3: accumulator and output register share the update edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      if (r_vld_pipe[1]) begin
        r_acc    <= w_res;
        r_sticky <= w_sticky_nxt;
      end
      // Not stalled means any held result is transferring this edge, so
      // out_valid simply follows whether a new group finishes now.
      r_out_valid <= w_s3_last;
      if (w_s3_last) begin
        r_out_data <= w_res;
        r_out_ovf  <= w_sticky_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule
